// File: rtl/domain_rr_arb2_if.sv
// Val/rdy stream carrying a message and the 2-bit security domain that labels it.
// The master drives val/msg/domain and the slave drives rdy.
interface domain_rr_arb2_if #(
   parameter int unsigned p_nbits = 32
);
   logic               val;
   logic               rdy;
   logic [p_nbits-1:0] msg;
   logic [1:0]         domain;

   modport master (
      output val,
      output msg,
      output domain,
      input  rdy
   );

   modport slave (
      input  val,
      input  msg,
      input  domain,
      output rdy
   );
endinterface

// File: rtl/domain_rr_arb2.sv
// Two-input round-robin arbiter feeding a one-entry output register.
// A message and its domain tag are always loaded, held and cleared together.
module domain_rr_arb2 #(
   parameter int unsigned p_nbits = 32
) (
   input  logic             clk,
   input  logic             reset,
   domain_rr_arb2_if.slave  in0,
   domain_rr_arb2_if.slave  in1,
   domain_rr_arb2_if.master out,
   output logic             sel
);

   typedef enum logic [0:0] {
      StEmpty,
      StFull
   } out_state_e;

   out_state_e         state_q, state_d;
   logic               prio_q, prio_d;
   logic [p_nbits-1:0] msg_q, msg_d;
   logic [1:0]         domain_q, domain_d;

   logic space;
   logic grant0;
   logic grant1;

   // Grants are suppressed during reset so no transfer is accepted.
   always_comb begin
      space  = (state_q == StEmpty) | out.rdy;
      grant0 = !reset & space & in0.val & (!in1.val | !prio_q);
      grant1 = !reset & space & in1.val & (!in0.val | prio_q);
   end

   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      msg_d    = msg_q;
      domain_d = domain_q;
      if (grant0) begin
         state_d  = StFull;
         prio_d   = 1'b1;
         msg_d    = in0.msg;
         domain_d = in0.domain;
      end else if (grant1) begin
         state_d  = StFull;
         prio_d   = 1'b0;
         msg_d    = in1.msg;
         domain_d = in1.domain;
      end else if ((state_q == StFull) && out.rdy) begin
         // Drained with nothing behind it: scrub so no labelled data lingers.
         state_d  = StEmpty;
         msg_d    = '0;
         domain_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StEmpty;
         prio_q   <= 1'b0;
         msg_q    <= '0;
         domain_q <= '0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         msg_q    <= msg_d;
         domain_q <= domain_d;
      end
   end

   assign in0.rdy    = grant0;
   assign in1.rdy    = grant1;
   assign sel        = grant1;
   assign out.val    = (state_q == StFull);
   assign out.msg    = msg_q;
   assign out.domain = domain_q;

   a_one_grant : assert property (@(posedge clk) !(grant0 && grant1));

   a_empty_clean : assert property (@(posedge clk) disable iff (reset)
      (state_q == StEmpty) |-> (msg_q == '0 && domain_q == '0));

   a_hold_stable : assert property (@(posedge clk) disable iff (reset)
      (out.val && !out.rdy) |=> ($stable(msg_q) && $stable(domain_q) && $stable(prio_q)));

endmodule
